// File: rtl/tb_run_ctrl.sv
// Run controller for the CPU simulation harness: sequences CPU reset, counts
// RUN cycles and stops the run on a self-loop, end-PC or cycle-budget timeout.
module tb_run_ctrl #(
  parameter int              PC_W       = 32,
  parameter int              CNT_W      = 32,
  parameter int              RST_CYCLES = 4,
  parameter int              MAX_CYCLES = 1000,
  parameter int              LOOP_LIMIT = 3,
  parameter int              STOP_MODE  = 1,
  parameter logic [PC_W-1:0] END_PC     = PC_W'(32'h0000_3040)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_reset,
  output logic             running,
  output logic             done,
  output logic             timed_out,
  output logic [CNT_W-1:0] cycles,
  output logic [PC_W-1:0]  halt_pc
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int SAME_W = $clog2(LOOP_LIMIT + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [SAME_W-1:0] LOOP_LAST = SAME_W'(LOOP_LIMIT - 1);
  localparam logic [SAME_W-1:0] SAME_MAX  = SAME_W'(LOOP_LIMIT);
  localparam logic [CNT_W-1:0]  CYC_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam bit                LOOP_EN   = (STOP_MODE == 1) || (STOP_MODE == 3);
  localparam bit                END_EN    = (STOP_MODE == 2) || (STOP_MODE == 3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [HOLD_W-1:0]  r_holdCnt;
  logic [SAME_W-1:0]  r_sameCnt;
  logic [PC_W-1:0]    r_prevPc;
  logic               r_prevValid;
  logic [CNT_W-1:0]   r_cycles;
  logic [PC_W-1:0]    r_haltPc;
  logic               r_timedOut;

  logic w_samePc;
  logic w_loopHit;
  logic w_endHit;
  logic w_timeout;
  logic w_halt;
  logic w_stop;

  // A program halt on the budget's last cycle wins over the timeout.
  assign w_samePc  = r_prevValid && (pc == r_prevPc);
  assign w_loopHit = LOOP_EN && w_samePc && (r_sameCnt == LOOP_LAST);
  assign w_endHit  = END_EN && (pc == END_PC);
  assign w_timeout = (r_cycles == CYC_LAST);
  assign w_halt    = w_loopHit || w_endHit;
  assign w_stop    = w_halt || w_timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    cpu_reset   = 1'b1;
    running     = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_nextState = HOLD;
      end
      HOLD: begin
        if (r_holdCnt == HOLD_LAST) w_nextState = RUN;
      end
      RUN: begin
        cpu_reset = 1'b0;
        running   = 1'b1;
        if (w_stop) w_nextState = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) w_nextState = HOLD;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_holdCnt   <= '0;
      r_sameCnt   <= '0;
      r_prevPc    <= '0;
      r_prevValid <= 1'b0;
      r_cycles    <= '0;
      r_haltPc    <= '0;
      r_timedOut  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (start) r_holdCnt <= '0;
        end
        HOLD: begin
          r_holdCnt <= r_holdCnt + HOLD_W'(1);
          if (r_holdCnt == HOLD_LAST) begin
            r_cycles    <= '0;
            r_timedOut  <= 1'b0;
            r_prevValid <= 1'b0;
            r_sameCnt   <= '0;
          end
        end
        RUN: begin
          // The stopping edge still counts, so the final count equals RUN cycles.
          r_cycles    <= r_cycles + CNT_W'(1);
          r_prevPc    <= pc;
          r_prevValid <= 1'b1;
          if (!w_samePc) begin
            r_sameCnt <= '0;
          end else if (r_sameCnt != SAME_MAX) begin
            r_sameCnt <= r_sameCnt + SAME_W'(1);
          end
          if (w_stop) begin
            r_haltPc   <= pc;
            r_timedOut <= !w_halt;
          end
        end
        default: ;
      endcase
    end
  end

  assign cycles    = r_cycles;
  assign halt_pc   = r_haltPc;
  assign timed_out = r_timedOut;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Bench for tb_run_ctrl: four instances (one per STOP_MODE) share pc traces and
// are checked against a trace-level prediction of where each run must stop.
module tb_tb_run_ctrl;

  localparam int          CNT_W = 16;
  localparam int          RST   = 4;
  localparam int          MAXC  = 24;
  localparam int          LOOP  = 3;
  localparam logic [31:0] ENDPC = 32'h0000_3040;

  logic             clk   = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      pc    = '0;
  logic [3:0]       cpuRstV;
  logic [3:0]       runV;
  logic [3:0]       doneV;
  logic [3:0]       toV;
  logic [CNT_W-1:0] cycV [4];
  logic [31:0]      hpcV [4];

  int total = 0;
  int bad   = 0;

  logic [31:0] trace [1:MAXC];
  int          expEnd [4];
  logic        expTo  [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    tb_run_ctrl #(
      .PC_W(32), .CNT_W(CNT_W), .RST_CYCLES(RST), .MAX_CYCLES(MAXC),
      .LOOP_LIMIT(LOOP), .STOP_MODE(g), .END_PC(ENDPC)
    ) dut (
      .clk(clk), .reset(reset), .start(start), .pc(pc),
      .cpu_reset(cpuRstV[g]), .running(runV[g]), .done(doneV[g]),
      .timed_out(toV[g]), .cycles(cycV[g]), .halt_pc(hpcV[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleAll(input string where);
    for (int g = 0; g < 4; g++) begin
      checkOutput($sformatf("%s m%0d cpu_reset", where, g), 32'(cpuRstV[g]), 32'd1);
      checkOutput($sformatf("%s m%0d running", where, g), 32'(runV[g]), 32'd0);
      checkOutput($sformatf("%s m%0d done", where, g), 32'(doneV[g]), 32'd0);
      checkOutput($sformatf("%s m%0d timed_out", where, g), 32'(toV[g]), 32'd0);
      checkOutput($sformatf("%s m%0d cycles", where, g), 32'(cycV[g]), 32'd0);
      checkOutput($sformatf("%s m%0d halt_pc", where, g), hpcV[g], 32'd0);
    end
  endtask

  // Stop point from the trace alone: longest run of equal PCs, END_PC hit, or budget.
  function automatic int predictEnd(input int mode, output logic to);
    int   runLen;
    logic loopHit;
    logic endHit;
    runLen = 0;
    to     = 1'b1;
    for (int n = 1; n <= MAXC; n++) begin
      runLen  = (n > 1 && trace[n] == trace[n-1]) ? runLen + 1 : 1;
      loopHit = (mode == 1 || mode == 3) && (runLen >= LOOP + 1);
      endHit  = (mode == 2 || mode == 3) && (trace[n] == ENDPC);
      if (loopHit || endHit) begin
        to = 1'b0;
        return n;
      end
    end
    return MAXC;
  endfunction

  function automatic void buildTrace(input int kind);
    logic [31:0] cur;
    int          r;
    cur = 32'h3000 + 32'(4 * $urandom_range(0, 8));
    for (int n = 1; n <= MAXC; n++) begin
      case (kind)
        0: trace[n] = (n < 3) ? 32'h3000 + 32'(4 * (n - 1)) : 32'h3008;
        1: trace[n] = 32'h3000 + 32'(4 * (n - 1));
        2: trace[n] = 32'h1000 + 32'(4 * (n - 1));
        3: trace[n] = ENDPC - 32'(4 * (MAXC - n));
        default: begin
          if (n > 1) begin
            r = $urandom_range(0, 99);
            if (r < 30)      cur = cur;
            else if (r < 85) cur = cur + 32'd4;
            else if (r < 92) cur = ENDPC;
            else             cur = 32'h3000 + 32'(4 * $urandom_range(0, 31));
          end
          trace[n] = cur;
        end
      endcase
    end
  endfunction

  // One full run: start, HOLD window, RUN trace, DONE; abortAt>0 resets mid-run.
  task automatic applyStimulus(input int kind, input int abortAt);
    int minEnd;
    buildTrace(kind);
    minEnd = MAXC;
    for (int g = 0; g < 4; g++) begin
      expEnd[g] = predictEnd(g, expTo[g]);
      if (expEnd[g] < minEnd) minEnd = expEnd[g];
    end
    start = 1'b1;
    tick();
    for (int h = 0; h < RST; h++) begin
      start = 1'($urandom_range(0, 1));
      for (int g = 0; g < 4; g++) begin
        checkOutput($sformatf("k%0d hold%0d m%0d cpu_reset", kind, h, g), 32'(cpuRstV[g]), 32'd1);
        checkOutput($sformatf("k%0d hold%0d m%0d running", kind, h, g), 32'(runV[g]), 32'd0);
        checkOutput($sformatf("k%0d hold%0d m%0d done", kind, h, g), 32'(doneV[g]), 32'd0);
      end
      tick();
    end
    for (int c = 1; c <= MAXC + 1; c++) begin
      if (c <= MAXC) pc = trace[c];
      start = (c <= minEnd) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      if (c == abortAt) begin
        start = 1'b0;
        reset = 1'b1;
        tick();
        checkIdleAll("midreset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
          tick();
          checkIdleAll("postreset");
        end
        return;
      end
      for (int g = 0; g < 4; g++) begin
        if (c <= expEnd[g]) begin
          checkOutput($sformatf("k%0d c%0d m%0d running", kind, c, g), 32'(runV[g]), 32'd1);
          checkOutput($sformatf("k%0d c%0d m%0d cpu_reset", kind, c, g), 32'(cpuRstV[g]), 32'd0);
          checkOutput($sformatf("k%0d c%0d m%0d done", kind, c, g), 32'(doneV[g]), 32'd0);
          checkOutput($sformatf("k%0d c%0d m%0d timed_out", kind, c, g), 32'(toV[g]), 32'd0);
          checkOutput($sformatf("k%0d c%0d m%0d cycles", kind, c, g), 32'(cycV[g]), 32'(c - 1));
        end else begin
          checkOutput($sformatf("k%0d c%0d m%0d done", kind, c, g), 32'(doneV[g]), 32'd1);
          checkOutput($sformatf("k%0d c%0d m%0d running", kind, c, g), 32'(runV[g]), 32'd0);
          checkOutput($sformatf("k%0d c%0d m%0d cpu_reset", kind, c, g), 32'(cpuRstV[g]), 32'd1);
          checkOutput($sformatf("k%0d c%0d m%0d cycles", kind, c, g), 32'(cycV[g]), 32'(expEnd[g]));
          checkOutput($sformatf("k%0d c%0d m%0d halt_pc", kind, c, g), hpcV[g], trace[expEnd[g]]);
          checkOutput($sformatf("k%0d c%0d m%0d timed_out", kind, c, g), 32'(toV[g]), 32'(expTo[g]));
        end
      end
      if (c <= MAXC) tick();
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    tick();
    checkIdleAll("reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkIdleAll("idle");
    end
    applyStimulus(0, 0);
    applyStimulus(1, 0);
    applyStimulus(2, 0);
    applyStimulus(3, 0);
    for (int i = 0; i < 20; i++) applyStimulus(4, 0);
    applyStimulus(4, $urandom_range(2, 5));
    for (int i = 0; i < 5; i++) applyStimulus(4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
